// File: rtl/viterbi_link_ctrl_pkg.sv
// Shared widths and FSM encoding for the Viterbi link sequencer.
package viterbi_link_ctrl_pkg;

  localparam int ENC_W = 8;
  localparam int DEC_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_RX = 3'd2,
    S_DRAIN   = 3'd3,
    S_GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/viterbi_link_ctrl_rise_det.sv
// Registered rising-edge detector: rise is high for the one cycle where x is high but was low.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic rise
);

  logic x_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= 1'b0;
    end else begin
      x_q <= x;
    end
  end

  assign rise = x & ~x_q;

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Sequencer for the Viterbi serial link: accepts an encoded word, runs the transmitter,
// waits for the receiver and hands the decoded nibble downstream, guarded by a watchdog.
module viterbi_link_ctrl
  import viterbi_link_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ENC_W-1:0] in_data,
  output logic             in_ready,
  output logic             tx_start,
  output logic [ENC_W-1:0] tx_data,
  input  logic             tx_done,
  output logic             rx_start,
  input  logic             rx_ready,
  input  logic [DEC_W-1:0] rx_data,
  output logic             out_valid,
  output logic [DEC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            tx_rise;
  logic            rx_rise;
  logic            wd_expired;

  rise_det u_tx_done_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (tx_done),
    .rise  (tx_rise)
  );

  rise_det u_rx_ready_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (rx_ready),
    .rise  (rx_rise)
  );

  assign wd_expired = (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wd_cnt      <= '0;
      in_ready    <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      rx_start    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            tx_data  <= in_data;
            tx_start <= 1'b1;
            rx_start <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            wd_cnt   <= '0;
            state    <= S_SEND;
          end else begin
            in_ready <= 1'b1;
          end
        end

        S_SEND: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A receiver result coinciding with tx done skips WAIT_RX entirely.
          if (tx_rise && rx_rise) begin
            out_data  <= rx_data;
            out_valid <= 1'b1;
            tx_start  <= 1'b0;
            state     <= S_DRAIN;
          end else if (tx_rise) begin
            state <= S_WAIT_RX;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            tx_start    <= 1'b0;
            state       <= S_GAP;
          end
        end

        S_WAIT_RX: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (rx_rise) begin
            out_data  <= rx_data;
            out_valid <= 1'b1;
            tx_start  <= 1'b0;
            state     <= S_DRAIN;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            tx_start    <= 1'b0;
            state       <= S_GAP;
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= S_GAP;
          end
        end

        // One dead cycle forces a visible tx_start low between consecutive words.
        S_GAP: begin
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          tx_start  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Scoreboard bench for viterbi_link_ctrl with a behavioural transmitter/receiver stand-in.
module tb_viterbi_link_ctrl;

  localparam int TO = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          rx_start;
  logic          rx_ready;
  logic [3:0]    rx_data;
  logic          out_valid;
  logic [3:0]    out_data;
  logic          out_ready;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] frame_cnt;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic [99:0] raw;

  always #5 clk = ~clk;

  viterbi_link_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .rx_start    (rx_start),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Delivered nibbles are popped and compared on the falling edge of each handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_exp));
      end
    end
  end

  task automatic wait_in_ready();
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) tick();
    if (in_ready !== 1'b1) check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [7:0] w);
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("tx_start_on_accept", 32'(tx_start), 32'd1);
    check("tx_data", 32'(tx_data), 32'(w));
  endtask

  task automatic send_word(input logic [7:0] w, input logic [3:0] nib, input int tl, input int rl);
    accept(w);
    repeat (tl) tick();
    tx_done = 1'b1;
    tick();
    check("tx_start_wait_rx", 32'(tx_start), 32'd1);
    check("out_valid_wait_rx", 32'(out_valid), 32'd0);
    repeat (rl) tick();
    rx_data  = nib;
    rx_ready = 1'b1;
    exp_q.push_back(nib);
    tick();
    check("out_valid_drain", 32'(out_valid), 32'd1);
    check("tx_start_drain", 32'(tx_start), 32'd0);
    rx_data   = ~nib;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tx_done   = 1'b0;
    rx_ready  = 1'b0;
    check("gap_in_ready", 32'(in_ready), 32'd0);
    check("gap_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; tx_done = 1'b0;
    rx_ready = 1'b0; rx_data = 4'h0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rx_start", 32'(rx_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);

    // 25 words carrying a 100-bit raw vector, four bits per word.
    for (int i = 0; i < 25; i++) raw[4*i +: 4] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 25; i++)
      send_word(8'hB4, raw[4*i +: 4], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    check("frame_cnt_25", 32'(frame_cnt), 32'd25);
    check("rx_start_held", 32'(rx_start), 32'd1);

    // tx_done and rx_ready rising together.
    accept(8'h5A);
    tx_done = 1'b1; rx_ready = 1'b1; rx_data = 4'h9;
    exp_q.push_back(4'h9);
    tick();
    check("same_cycle_out_valid", 32'(out_valid), 32'd1);
    check("same_cycle_out_data", 32'(out_data), 32'h9);
    check("same_cycle_tx_start", 32'(tx_start), 32'd0);
    rx_data = 4'h0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; tx_done = 1'b0; rx_ready = 1'b0;
    tick();
    check("frame_cnt_26", 32'(frame_cnt), 32'd26);

    // Downstream backpressure for 10 cycles.
    accept(8'hC3);
    tx_done = 1'b1;
    tick();
    rx_ready = 1'b1; rx_data = 4'h6;
    exp_q.push_back(4'h6);
    tick();
    for (int i = 0; i < 10; i++) begin
      rx_data = 4'($urandom_range(0, 15));
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h6);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_frame_cnt", 32'(frame_cnt), 32'd26);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; tx_done = 1'b0; rx_ready = 1'b0;
    check("frame_cnt_27", 32'(frame_cnt), 32'd27);
    tick();

    // Watchdog: tx_done already high before the word, so no edge ever arrives.
    tx_done = 1'b1;
    tick();
    tick();
    accept(8'h11);
    repeat (TO - 1) tick();
    check("wd_not_yet", 32'(timeout_err), 32'd0);
    check("wd_tx_start_held", 32'(tx_start), 32'd1);
    tick();
    check("wd_timeout_err", 32'(timeout_err), 32'd1);
    check("wd_tx_start_drop", 32'(tx_start), 32'd0);
    check("wd_no_out_valid", 32'(out_valid), 32'd0);
    check("wd_gap_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("wd_idle_in_ready", 32'(in_ready), 32'd1);
    tx_done = 1'b0;
    tick();
    check("wd_sticky", 32'(timeout_err), 32'd1);
    check("wd_frame_cnt", 32'(frame_cnt), 32'd27);

    // A stale timeout does not block traffic; counter wraps at 2^CW.
    send_word(8'hB4, 4'hE, 1, 1);
    check("frame_cnt_28", 32'(frame_cnt), 32'd28);
    for (int i = 0; i < 4; i++) send_word(8'h3C, 4'(i + 1), 0, 0);
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    check("timeout_still_set", 32'(timeout_err), 32'd1);

    // Reset during WAIT_RX abandons the word.
    accept(8'h77);
    tx_done = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1; tx_done = 1'b0;
    rx_data = 4'hA; rx_ready = 1'b1; out_ready = 1'b1;
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_rx_ignored", 32'(out_valid), 32'd0);
    end
    rx_ready = 1'b0; out_ready = 1'b0;
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
